tri_wireframe_seq: RTL and testbench

//  Upstream sequencer for the Bresenham line drawer. Accepts one screen-space triangle (3 vertices + colour)
//  via valid/ready, drives the drawer once per edge (v0->v1, v1->v2, v2->v0) and turns its pixel stream

---
 rtl/renderer_pkg.sv | 21 ++
 rtl/tri_wireframe_seq.sv | 89 ++++++++
 tb/tb_tri_wireframe_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/renderer_pkg.sv
// renderer_pkg: shared screen defaults, vertex/triangle types and sequencer states
package renderer_pkg;
  localparam int H_RES_D = 640;
  localparam int V_RES_D = 480;
  localparam int COLOR_W_D = 8;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } vertex_t;
  typedef struct packed {
    vertex_t [2:0]        v;
    logic [COLOR_W_D-1:0] color;
  } tri_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DRAW,
    S_RELEASE,
    S_FINISH
  } seq_state_e;
endpackage

// File: rtl/tri_wireframe_seq.sv
// tri_wireframe_seq: walks a triangle's three edges through the line drawer and emits clipped framebuffer writes
module tri_wireframe_seq import renderer_pkg::*; #(
  parameter int H_RES   = H_RES_D,
  parameter int V_RES   = V_RES_D,
  parameter int COLOR_W = COLOR_W_D,
  parameter int ADDR_W  = 19
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [9:0]         tri_x0,
  input  logic [9:0]         tri_x1,
  input  logic [9:0]         tri_x2,
  input  logic [9:0]         tri_y0,
  input  logic [9:0]         tri_y1,
  input  logic [9:0]         tri_y2,
  input  logic [COLOR_W-1:0] tri_color,
  output logic               tri_done,
  output logic               line_start,
  output logic [9:0]         line_x0,
  output logic [9:0]         line_x1,
  output logic [9:0]         line_y0,
  output logic [9:0]         line_y1,
  input  logic [9:0]         line_DrawX,
  input  logic [9:0]         line_DrawY,
  input  logic               line_done,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data
);
  seq_state_e         state_q, state_d;
  logic [1:0]         edge_q, edge_d;
  vertex_t [2:0]      vtx_q, vtx_d;
  logic [COLOR_W-1:0] color_q, color_d;
  vertex_t            va, vb;
  logic               in_range;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      edge_q  <= '0;
      vtx_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      vtx_q   <= vtx_d;
      color_q <= color_d;
    end
  end
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    vtx_d   = vtx_q;
    color_d = color_q;
    case (state_q)
      S_IDLE: if (tri_valid) begin
        vtx_d[0] = '{x: tri_x0, y: tri_y0};
        vtx_d[1] = '{x: tri_x1, y: tri_y1};
        vtx_d[2] = '{x: tri_x2, y: tri_y2};
        color_d  = tri_color;
        edge_d   = '0;
        state_d  = S_START;
      end
      S_START:   state_d = S_DRAW;
      S_DRAW:    state_d = line_done ? S_RELEASE : S_DRAW;
      S_RELEASE: begin
        edge_d  = edge_q == 2'd2 ? edge_q : edge_q + 2'd1;
        state_d = edge_q == 2'd2 ? S_FINISH : S_START;
      end
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end
  // edge 2 closes the loop back to vertex 0
  assign va = vtx_q[edge_q];
  assign vb = vtx_q[edge_q == 2'd2 ? 2'd0 : edge_q + 2'd1];
  assign line_x0 = va.x;
  assign line_y0 = va.y;
  assign line_x1 = vb.x;
  assign line_y1 = vb.y;
  assign tri_ready  = state_q == S_IDLE;
  assign line_start = state_q == S_START || state_q == S_DRAW;
  assign tri_done   = state_q == S_FINISH;
  assign in_range = 32'(line_DrawX) < H_RES && 32'(line_DrawY) < V_RES;
  assign fb_we    = state_q == S_DRAW && !line_done && in_range;
  assign fb_addr  = ADDR_W'(line_DrawY) * ADDR_W'(H_RES) + ADDR_W'(line_DrawX);
  assign fb_data  = color_q;
endmodule

// File: tb/tb_tri_wireframe_seq.sv
// tb_tri_wireframe_seq: drives the sequencer with a behavioural Bresenham drawer and scoreboards every write
module tb_tri_wireframe_seq;
  localparam int H = 640;
  localparam int V = 480;
  logic       Clk = 0, Reset = 1;
  logic       tri_valid = 0, tri_ready, tri_done, line_start, line_done, fb_we;
  logic [9:0] tri_x0 = 0, tri_x1 = 0, tri_x2 = 0, tri_y0 = 0, tri_y1 = 0, tri_y2 = 0;
  logic [7:0] tri_color = 0, fb_data;
  logic [9:0] line_x0, line_x1, line_y0, line_y1, line_DrawX, line_DrawY;
  logic [18:0] fb_addr;

  tri_wireframe_seq dut (
    .Clk(Clk), .Reset(Reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_x0(tri_x0), .tri_x1(tri_x1), .tri_x2(tri_x2),
    .tri_y0(tri_y0), .tri_y1(tri_y1), .tri_y2(tri_y2),
    .tri_color(tri_color), .tri_done(tri_done), .line_start(line_start),
    .line_x0(line_x0), .line_x1(line_x1), .line_y0(line_y0), .line_y1(line_y1),
    .line_DrawX(line_DrawX), .line_DrawY(line_DrawY), .line_done(line_done),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_bad = 0, cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // behavioural line drawer: waits for start, walks L+1 pixels, then holds done until start drops
  typedef enum {D_WAIT, D_DRAW, D_DONE} dst_e;
  dst_e ds = D_WAIT;
  int px = 0, py = 0, ex = 0, ey = 0, sx = 0, sy = 0, ddx = 0, ddy = 0, err = 0;
  int adx, ady, e2, ne;
  always @(posedge Clk) begin
    if (Reset) ds <= D_WAIT;
    else if (ds == D_WAIT) begin
      if (line_start) begin
        adx = int'(line_x1) - int'(line_x0);
        ady = int'(line_y1) - int'(line_y0);
        sx  <= adx >= 0 ? 1 : -1;
        sy  <= ady >= 0 ? 1 : -1;
        adx = adx < 0 ? -adx : adx;
        ady = ady < 0 ? -ady : ady;
        px <= line_x0; py <= line_y0; ex <= line_x1; ey <= line_y1;
        ddx <= adx; ddy <= -ady; err <= adx - ady;
        ds <= D_DRAW;
      end
    end else if (ds == D_DRAW) begin
      if (px == ex && py == ey) ds <= D_DONE;
      else begin
        e2 = 2 * err;
        ne = err;
        if (e2 >= ddy) begin ne += ddy; px <= px + sx; end
        if (e2 <= ddx) begin ne += ddx; py <= py + sy; end
        err <= ne;
      end
    end else if (!line_start) ds <= D_WAIT;
  end
  assign line_DrawX = 10'(ds == D_DONE ? ex : px);
  assign line_DrawY = 10'(ds == D_DONE ? ey : py);
  assign line_done  = ds == D_DONE;

  // monitor: latches the accepted triangle, checks edge endpoints and every framebuffer write
  int ax[3], ay[3], acol;
  int eidx = 0, nw = 0, f_addr = -1, ndone = 0, nacc = 0, acc_cyc = 0, done_cyc = 0;
  bit exp_we;
  always @(negedge Clk) begin
    if (!Reset && tri_valid && tri_ready) begin
      ax = '{int'(tri_x0), int'(tri_x1), int'(tri_x2)};
      ay = '{int'(tri_y0), int'(tri_y1), int'(tri_y2)};
      acol = tri_color; acc_cyc = cyc; nacc++;
      eidx = 0; nw = 0; f_addr = -1;
    end
    if (!Reset && ds == D_WAIT && line_start) begin
      chk("edge endpoints", {line_x0, line_y0, line_x1, line_y1},
          {10'(ax[eidx % 3]), 10'(ay[eidx % 3]), 10'(ax[(eidx + 1) % 3]), 10'(ay[(eidx + 1) % 3])});
      eidx++;
    end
    exp_we = ds == D_DRAW && px < H && py < V;
    if (exp_we || fb_we) begin
      chk("fb write", {fb_we, fb_addr, fb_data}, {exp_we, 19'(py * H + px), 8'(acol)});
      if (fb_we) begin
        if (nw == 0) f_addr = fb_addr;
        nw++;
      end
    end
    if (tri_done) begin done_cyc = cyc; ndone++; end
  end

  typedef struct {
    int x[3];
    int y[3];
    int col;
    int lat;
    int writes;
    int first;
  } vec_t;

  function automatic int span(input int a, input int b, input int c, input int d);
    int u = c > a ? c - a : a - c;
    int w = d > b ? d - b : b - d;
    return u > w ? u : w;
  endfunction

  task automatic wait_done(input string nm);
    int d0 = ndone;
    for (int i = 0; i < 3000 && ndone == d0; i++) begin @(negedge Clk); #1; end
    if (ndone == d0) chk({nm, " done timeout"}, 0, 1);
  endtask

  task automatic drive(input vec_t v);
    tri_x0 = 10'(v.x[0]); tri_x1 = 10'(v.x[1]); tri_x2 = 10'(v.x[2]);
    tri_y0 = 10'(v.y[0]); tri_y1 = 10'(v.y[1]); tri_y2 = 10'(v.y[2]);
    tri_color = 8'(v.col);
  endtask

  task automatic run_tri(input vec_t v, input string nm);
    @(posedge Clk); #1;
    chk({nm, " ready"}, tri_ready, 1);
    drive(v);
    tri_valid = 1;
    @(posedge Clk); #1;
    tri_valid = 0;
    wait_done(nm);
    chk({nm, " latency"}, done_cyc - acc_cyc, v.lat);
    chk({nm, " writes"}, nw, v.writes);
    chk({nm, " first addr"}, f_addr, v.first);
  endtask

  vec_t tbl[3];
  vec_t r;
  int a0, d0, w0;

  initial begin
    tbl[0] = '{'{10, 20, 10}, '{10, 10, 20}, 'h5a, 43, 33, 6410};
    tbl[1] = '{'{5, 5, 5}, '{5, 5, 5}, 'h3c, 13, 3, 3205};
    tbl[2] = '{'{630, 700, 630}, '{470, 470, 500}, 'hff, 183, 20, 301430};
    repeat (2) @(posedge Clk);
    #1;
    chk("reset tri_ready", tri_ready, 1);
    chk("reset fb_we", fb_we, 0);
    chk("reset line_start", line_start, 0);
    chk("reset tri_done", tri_done, 0);
    @(negedge Clk); Reset = 0;

    for (int i = 0; i < 3; i++) run_tri(tbl[i], $sformatf("table%0d", i));

    for (int i = 0; i < 8; i++) begin
      r.lat = 1; r.writes = 0;
      for (int k = 0; k < 3; k++) begin
        r.x[k] = $urandom_range(0, H - 1);
        r.y[k] = $urandom_range(0, V - 1);
      end
      for (int k = 0; k < 3; k++) begin
        r.lat += span(r.x[k], r.y[k], r.x[(k + 1) % 3], r.y[(k + 1) % 3]) + 4;
        r.writes += span(r.x[k], r.y[k], r.x[(k + 1) % 3], r.y[(k + 1) % 3]) + 1;
      end
      r.col = $urandom_range(0, 255);
      r.first = r.y[0] * H + r.x[0];
      run_tri(r, $sformatf("rand%0d", i));
    end

    // reset in the middle of the second edge
    r = '{'{100, 300, 50}, '{100, 150, 300}, 'h11, 0, 0, 0};
    @(posedge Clk); #1;
    drive(r); tri_valid = 1;
    @(posedge Clk); #1; tri_valid = 0;
    for (int i = 0; i < 500 && eidx < 2; i++) begin @(negedge Clk); #1; end
    chk("reached edge 1", eidx, 2);
    repeat (5) @(negedge Clk);
    #1 Reset = 1;
    @(posedge Clk); #1;
    chk("midreset fb_we", fb_we, 0);
    chk("midreset tri_ready", tri_ready, 1);
    chk("midreset line_start", line_start, 0);
    @(negedge Clk); #1 Reset = 0;
    d0 = ndone; w0 = nw;
    repeat (100) @(negedge Clk);
    #1;
    chk("midreset no tri_done", ndone, d0);
    chk("midreset no writes", nw, w0);
    chk("midreset idle", tri_ready, 1);

    // back-to-back with tri_valid held high
    @(posedge Clk); #1;
    drive(tbl[0]); tri_valid = 1;
    @(posedge Clk); #1;
    drive(tbl[1]);
    wait_done("b2b A");
    chk("b2b A writes", nw, 33);
    chk("b2b ready during done", tri_ready, 0);
    a0 = nacc;
    for (int i = 0; i < 5 && nacc == a0; i++) begin @(negedge Clk); #1; end
    chk("b2b second accept cycle", acc_cyc - done_cyc, 1);
    @(posedge Clk); #1 tri_valid = 0;
    wait_done("b2b B");
    chk("b2b B latency", done_cyc - acc_cyc, 13);
    chk("b2b B writes", nw, 3);
    chk("b2b B first addr", f_addr, 3205);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
